// File: rtl/bids22_round_ctrl_if.sv
// Host round request/result handshake plus the bids22 command and result ports.
// master = round controller side, slave = host and auction unit side.
interface bids22_round_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              cfg_valid;
  logic              cfg_ready;
  logic [DATA_W-1:0] cfg_key;
  logic [DATA_W-1:0] cfg_x_bal;
  logic [DATA_W-1:0] cfg_y_bal;
  logic [DATA_W-1:0] cfg_z_bal;
  logic [2:0]        cfg_mask;
  logic [DATA_W-1:0] cfg_cost;
  logic [DATA_W-1:0] cfg_duration;
  logic              abort;
  logic [3:0]        C_op;
  logic [DATA_W-1:0] C_data;
  logic              C_start;
  logic              ready;
  logic              roundOver;
  logic [DATA_W-1:0] maxBid;
  logic              X_win;
  logic              Y_win;
  logic              Z_win;
  logic [1:0]        err;
  logic              res_valid;
  logic              res_ack;
  logic [1:0]        res_winner;
  logic [DATA_W-1:0] res_maxBid;
  logic [1:0]        res_err;
  logic              res_timeout;

  modport master (
    input  cfg_valid, cfg_key, cfg_x_bal, cfg_y_bal, cfg_z_bal, cfg_mask,
           cfg_cost, cfg_duration, abort, ready, roundOver, maxBid,
           X_win, Y_win, Z_win, err, res_ack,
    output cfg_ready, C_op, C_data, C_start, res_valid, res_winner,
           res_maxBid, res_err, res_timeout
  );

  modport slave (
    output cfg_valid, cfg_key, cfg_x_bal, cfg_y_bal, cfg_z_bal, cfg_mask,
           cfg_cost, cfg_duration, abort, ready, roundOver, maxBid,
           X_win, Y_win, Z_win, err, res_ack,
    input  cfg_ready, C_op, C_data, C_start, res_valid, res_winner,
           res_maxBid, res_err, res_timeout
  );
endinterface

// File: rtl/bids22_round_ctrl.sv
// Round sequencer for bids22: replays a host config as commands, runs, collects the winner, unlocks.
// All outputs registered; command states stall on ready=0, results held until res_ack.
module bids22_round_ctrl #(
  parameter int DATA_W     = 32,
  parameter int RO_TIMEOUT = 16
) (
  input logic                 clk,
  input logic                 reset_n,
  bids22_round_ctrl_if.master bus
);
  localparam int TW = $clog2(RO_TIMEOUT + 1);

  localparam logic [3:0] OP_NOOP   = 4'd0;
  localparam logic [3:0] OP_UNLOCK = 4'd1;
  localparam logic [3:0] OP_LOCK   = 4'd2;
  localparam logic [3:0] OP_LOADX  = 4'd3;
  localparam logic [3:0] OP_LOADY  = 4'd4;
  localparam logic [3:0] OP_LOADZ  = 4'd5;
  localparam logic [3:0] OP_MASK   = 4'd6;
  localparam logic [3:0] OP_TIMER  = 4'd7;
  localparam logic [3:0] OP_CHARGE = 4'd8;

  typedef enum logic [3:0] {
    IDLE, LDX, LDY, LDZ, MASK, COST, TMR, LOCK, RUN, WAIT_RO, REPORT, UNLK
  } state_t;

  state_t            state, state_d;
  logic [DATA_W-1:0] key_q, xbal_q, ybal_q, zbal_q, cost_q, dur_q;
  logic [2:0]        mask_q;
  logic [DATA_W-1:0] run_cnt, run_cnt_d;
  logic [TW-1:0]     tmo_cnt, tmo_cnt_d;
  logic              cfg_ready_q, cfg_ready_d;
  logic [3:0]        c_op_q, c_op_d;
  logic [DATA_W-1:0] c_data_q, c_data_d;
  logic              c_start_q, c_start_d;
  logic              res_valid_q, res_valid_d;
  logic [1:0]        res_winner_q, res_winner_d;
  logic [DATA_W-1:0] res_max_bid_q, res_max_bid_d;
  logic [1:0]        res_err_q, res_err_d;
  logic              res_timeout_q, res_timeout_d;
  logic              accept;
  logic [1:0]        winner;

  assign accept = (state == IDLE) && bus.cfg_valid && cfg_ready_q;

  // Ambiguous results (no flag or several flags) report no winner.
  always_comb begin
    winner = 2'd0;
    case ({bus.Z_win, bus.Y_win, bus.X_win})
      3'b001:  winner = 2'd1;
      3'b010:  winner = 2'd2;
      3'b100:  winner = 2'd3;
      default: winner = 2'd0;
    endcase
  end

  always_comb begin
    state_d       = state;
    run_cnt_d     = run_cnt;
    tmo_cnt_d     = tmo_cnt;
    cfg_ready_d   = 1'b0;
    c_op_d        = OP_NOOP;
    c_data_d      = '0;
    c_start_d     = 1'b0;
    res_valid_d   = res_valid_q;
    res_winner_d  = res_winner_q;
    res_max_bid_d = res_max_bid_q;
    res_err_d     = res_err_q;
    res_timeout_d = res_timeout_q;

    case (state)
      IDLE: begin
        cfg_ready_d = 1'b1;
        if (accept) begin
          cfg_ready_d   = 1'b0;
          state_d       = LDX;
          res_valid_d   = 1'b0;
          res_winner_d  = 2'd0;
          res_max_bid_d = '0;
          res_err_d     = 2'd0;
          res_timeout_d = 1'b0;
        end
      end
      LDX: if (bus.ready) begin
        c_op_d   = OP_LOADX;
        c_data_d = xbal_q;
        state_d  = LDY;
      end
      LDY: if (bus.ready) begin
        c_op_d   = OP_LOADY;
        c_data_d = ybal_q;
        state_d  = LDZ;
      end
      LDZ: if (bus.ready) begin
        c_op_d   = OP_LOADZ;
        c_data_d = zbal_q;
        state_d  = MASK;
      end
      MASK: if (bus.ready) begin
        c_op_d   = OP_MASK;
        c_data_d = {{(DATA_W-3){1'b0}}, mask_q};
        state_d  = COST;
      end
      COST: if (bus.ready) begin
        c_op_d   = OP_CHARGE;
        c_data_d = cost_q;
        state_d  = TMR;
      end
      TMR: if (bus.ready) begin
        c_op_d   = OP_TIMER;
        c_data_d = dur_q;
        state_d  = LOCK;
      end
      LOCK: if (bus.ready) begin
        c_op_d    = OP_LOCK;
        c_data_d  = key_q;
        state_d   = RUN;
        run_cnt_d = (dur_q == '0) ? DATA_W'(1) : dur_q;
      end
      RUN: begin
        // First RUN edge raises C_start without counting, so the count equals high cycles.
        if (bus.abort || (c_start_q && run_cnt == DATA_W'(1))) begin
          state_d   = WAIT_RO;
          tmo_cnt_d = TW'(RO_TIMEOUT);
        end else if (!c_start_q) begin
          c_start_d = 1'b1;
        end else begin
          c_start_d = 1'b1;
          run_cnt_d = run_cnt - DATA_W'(1);
        end
      end
      WAIT_RO: begin
        if (bus.roundOver) begin
          state_d       = REPORT;
          res_valid_d   = 1'b1;
          res_winner_d  = winner;
          res_max_bid_d = bus.maxBid;
          res_err_d     = bus.err;
          res_timeout_d = 1'b0;
        end else if (tmo_cnt <= TW'(1)) begin
          state_d       = REPORT;
          res_valid_d   = 1'b1;
          res_winner_d  = 2'd0;
          res_max_bid_d = '0;
          res_err_d     = 2'd0;
          res_timeout_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt - TW'(1);
        end
      end
      REPORT: if (bus.res_ack) begin
        res_valid_d = 1'b0;
        state_d     = UNLK;
      end
      UNLK: if (bus.ready) begin
        c_op_d   = OP_UNLOCK;
        c_data_d = key_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      run_cnt       <= '0;
      tmo_cnt       <= '0;
      cfg_ready_q   <= 1'b0;
      c_op_q        <= OP_NOOP;
      c_data_q      <= '0;
      c_start_q     <= 1'b0;
      res_valid_q   <= 1'b0;
      res_winner_q  <= 2'd0;
      res_max_bid_q <= '0;
      res_err_q     <= 2'd0;
      res_timeout_q <= 1'b0;
    end else begin
      state         <= state_d;
      run_cnt       <= run_cnt_d;
      tmo_cnt       <= tmo_cnt_d;
      cfg_ready_q   <= cfg_ready_d;
      c_op_q        <= c_op_d;
      c_data_q      <= c_data_d;
      c_start_q     <= c_start_d;
      res_valid_q   <= res_valid_d;
      res_winner_q  <= res_winner_d;
      res_max_bid_q <= res_max_bid_d;
      res_err_q     <= res_err_d;
      res_timeout_q <= res_timeout_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_q  <= '0;
      xbal_q <= '0;
      ybal_q <= '0;
      zbal_q <= '0;
      mask_q <= 3'd0;
      cost_q <= '0;
      dur_q  <= '0;
    end else if (accept) begin
      key_q  <= bus.cfg_key;
      xbal_q <= bus.cfg_x_bal;
      ybal_q <= bus.cfg_y_bal;
      zbal_q <= bus.cfg_z_bal;
      mask_q <= bus.cfg_mask;
      cost_q <= bus.cfg_cost;
      dur_q  <= bus.cfg_duration;
    end
  end

  assign bus.cfg_ready   = cfg_ready_q;
  assign bus.C_op        = c_op_q;
  assign bus.C_data      = c_data_q;
  assign bus.C_start     = c_start_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_winner  = res_winner_q;
  assign bus.res_maxBid  = res_max_bid_q;
  assign bus.res_err     = res_err_q;
  assign bus.res_timeout = res_timeout_q;
endmodule
